// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store unit.
//
// Takes the EX-stage ALU result as the effective address plus the rs2 store
// value, runs one access against the data memory, and returns the formatted
// load value toward MEM/WB.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   ADDRESS[31:0]       effective address
//   STORE_DATA[31:0]    rs2 value
//   MEM_READ, MEM_WRITE load / store request from EX/MEM
//   FUNCT3[2:0]         access size and signedness
//   DMEM_RDATA[31:0]    read word from data memory
//   DMEM_BUSYWAIT       memory not ready
//   DMEM_ADDR[31:0]     word-aligned address (registered)
//   DMEM_WDATA[31:0]    lane-replicated store data (registered)
//   DMEM_WSTRB[3:0]     byte enables, 0000 for reads (registered)
//   DMEM_READ/WRITE     access strobes (registered)
//   LOAD_DATA[31:0]     formatted load result (registered)
//   BUSYWAIT            pipeline stall (combinational)
//   FAULT               misaligned / illegal request (combinational)
//   BUS_ERROR           one-cycle timeout abort pulse (0 when timeout disabled)
//   DBG_STATE[1:0]      current FSM state, for observation only
//
// Handshake: a request is the level MEM_READ|MEM_WRITE held by the pipeline;
// the unit answers with BUSYWAIT=1 until the access has finished, and the
// pipeline advances on the first cycle BUSYWAIT is 0. Toward memory, the
// strobe is held until a cycle where DMEM_BUSYWAIT is sampled 0, which
// completes the transfer on that edge.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has been
// waiting TIMEOUT_CYCLES cycles in ACCESS, pulsing BUS_ERROR.

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] STORE_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_WSTRB,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        FAULT,
  output logic        BUS_ERROR,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        req;
  logic        f3_ok;
  logic        misaligned;
  logic        bad_req;
  logic        start;
  logic        timeout;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Request legality. FUNCT3[1:0] encodes the size for every legal code
  // (00 byte, 01 half, 10 word), so alignment only looks at those bits.
  always_comb begin
    req = MEM_READ | MEM_WRITE;
    case (FUNCT3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = MEM_READ;  // unsigned forms are load-only
      default:                f3_ok = 1'b0;
    endcase
    case (FUNCT3[1:0])
      2'b01:   misaligned = ADDRESS[0];
      2'b10:   misaligned = |ADDRESS[1:0];
      default: misaligned = 1'b0;
    endcase
    bad_req = (MEM_READ & MEM_WRITE) | ~f3_ok | misaligned;
  end

  assign start    = (state == IDLE) & req & ~bad_req;
  assign FAULT    = (state == IDLE) & req & bad_req;
  assign BUSYWAIT = start | (state == ACCESS);
  assign DBG_STATE = state;

  // Store lane steering: replicate the datum across the word and enable
  // only the addressed lanes.
  always_comb begin
    case (FUNCT3[1:0])
      2'b00: begin
        st_wdata = {4{STORE_DATA[7:0]}};
        st_wstrb = 4'b0001 << ADDRESS[1:0];
      end
      2'b01: begin
        st_wdata = {2{STORE_DATA[15:0]}};
        st_wstrb = 4'b0011 << ADDRESS[1:0];
      end
      default: begin
        st_wdata = STORE_DATA;
        st_wstrb = 4'b1111;
      end
    endcase
    if (MEM_READ) begin
      st_wdata = 32'h0;
      st_wstrb = 4'b0000;
    end
  end

  // Load formatting from the offset and FUNCT3 captured at issue.
  always_comb begin
    ld_byte = DMEM_RDATA[8*off_q +: 8];
    ld_half = off_q[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = DMEM_RDATA;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 bus_error_q;
  // cnt_q counts completed ACCESS cycles, so the check fires on the
  // TIMEOUT_CYCLES-th cycle still waiting.
  assign timeout   = DMEM_BUSYWAIT & (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign BUS_ERROR = bus_error_q;
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES[0] ^ CNT_WIDTH[0];
  assign timeout    = 1'b0;
  assign BUS_ERROR  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      DMEM_ADDR  <= 32'h0;
      DMEM_WDATA <= 32'h0;
      DMEM_WSTRB <= 4'b0000;
      DMEM_READ  <= 1'b0;
      DMEM_WRITE <= 1'b0;
      LOAD_DATA  <= 32'h0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      bus_error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            DMEM_ADDR  <= {ADDRESS[31:2], 2'b00};
            DMEM_WDATA <= st_wdata;
            DMEM_WSTRB <= st_wstrb;
            DMEM_READ  <= MEM_READ;
            DMEM_WRITE <= MEM_WRITE;
            off_q      <= ADDRESS[1:0];
            f3_q       <= FUNCT3;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!DMEM_BUSYWAIT) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            if (DMEM_READ) LOAD_DATA <= ld_fmt;
            state      <= DONE;
          end else if (timeout) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_error_q <= 1'b1;
`endif
            state      <= DONE;
          end else begin
`ifdef MEM_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        // One release cycle; returning to IDLE unconditionally stops the
        // still-asserted request from starting a second access.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized
// transactions, checked every cycle against a transaction-level model.
module tb_mem_access_unit;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] address = '0, store_data = '0, dmem_rdata = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, dmem_busywait = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_wstrb;
  logic        dmem_read, dmem_write, busywait, fault, bus_error;
  logic [1:0]  dbg_state;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
    .CLK(clk), .RESET(reset), .ADDRESS(address), .STORE_DATA(store_data),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .FUNCT3(funct3),
    .DMEM_RDATA(dmem_rdata), .DMEM_BUSYWAIT(dmem_busywait),
    .DMEM_ADDR(dmem_addr), .DMEM_WDATA(dmem_wdata), .DMEM_WSTRB(dmem_wstrb),
    .DMEM_READ(dmem_read), .DMEM_WRITE(dmem_write), .LOAD_DATA(load_data),
    .BUSYWAIT(busywait), .FAULT(fault), .BUS_ERROR(bus_error),
    .DBG_STATE(dbg_state)
  );

  // ---------------- model state ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int stall_cnt = 0;

  logic        m_busy = 0, m_fault = 0, m_read = 0, m_write = 0, m_bus_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_load = 0;
  logic [3:0]  m_wstrb = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Size in bytes of an access is 1, 2 or 4; legal when aligned to it.
  function automatic bit legal_req(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int unsigned size;
    if (rd && wr) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    size = 1 << (f3 % 4);
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] fmt_load(logic [31:0] rdata, int unsigned off, logic [2:0] f3);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] store_wdata(logic [2:0] f3, logic [31:0] sd);
    case (f3 % 4)
      0:       return (sd & 32'hFF) * 32'h01010101;
      1:       return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(logic [2:0] f3, int unsigned off);
    case (f3 % 4)
      0:       return 4'(1 << off);
      1:       return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      stall_cnt += int'(busywait);
      check32("busywait", 32'(busywait), 32'(m_busy));
      check32("fault", 32'(fault), 32'(m_fault));
      check32("dmem_read", 32'(dmem_read), 32'(m_read));
      check32("dmem_write", 32'(dmem_write), 32'(m_write));
      check32("bus_error", 32'(bus_error), 32'(m_bus_err));
      check32("dmem_addr", dmem_addr, m_addr);
      check32("dmem_wstrb", 32'(dmem_wstrb), 32'(m_wstrb));
      check32("load_data", load_data, m_load);
      if (m_write) check32("dmem_wdata", dmem_wdata, m_wdata);
    end
  end

  // ---------------- driver ----------------
  // Called and returns at #1 after a rising edge, with the FSM idle.
  task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int waits,
                        input bit to, input bit hold_done, output int stalls);
    bit ok;
    int n_access;
    mem_read = rd; mem_write = wr; funct3 = f3; address = a;
    store_data = sd; dmem_rdata = rdata;
    dmem_busywait = to || (waits > 0);
    ok = (rd || wr) && legal_req(rd, wr, f3, a);
    m_fault = (rd || wr) && !ok;
    m_busy = ok;
    stall_cnt = 0;
    @(posedge clk); #1;
    if (!ok) begin
      mem_read = 0; mem_write = 0;
      m_fault = 0; m_busy = 0;
      stalls = 0;
      return;
    end
    m_addr = a & ~32'h3;
    m_wstrb = wr ? store_strb(f3, a % 4) : 4'h0;
    if (wr) m_wdata = store_wdata(f3, sd);
    m_read = rd; m_write = wr; m_busy = 1; m_fault = 0;
    if (rd && !to) exp_q.push_back(fmt_load(rdata, a % 4, f3));
    n_access = to ? TMO : waits + 1;
    for (int i = 0; i < n_access; i++) begin
      dmem_busywait = to || (i < waits);
      @(posedge clk); #1;
    end
    // release cycle
    m_read = 0; m_write = 0; m_busy = 0; m_bus_err = to;
    if (rd && !to) m_load = exp_q.pop_front();
    dmem_busywait = 1'($urandom_range(0, 1));
    if (!hold_done) begin mem_read = 0; mem_write = 0; end
    @(posedge clk); #1;
    m_bus_err = 0;
    mem_read = 0; mem_write = 0;
    stalls = stall_cnt;
    check32("stall_len", 32'(stalls), 32'(n_access + 1));
  endtask

  // ---------------- stimulus ----------------
  int st;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;           // outputs must already be in reset state
    @(posedge clk); #1;
    check32("reset_fsm_idle", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // pin the model with hand-computed values
    check32("model_lb", fmt_load(32'h12F03456, 2, 3'd0), 32'hFFFFFFF0);
    check32("model_lbu", fmt_load(32'h12F03456, 2, 3'd4), 32'h000000F0);
    check32("model_sb_wdata", store_wdata(3'd0, 32'hA5), 32'hA5A5A5A5);
    check32("model_sb_strb", 32'(store_strb(3'd0, 3)), 32'h8);

    // 1: SW, zero-wait
    do_txn(1'b0, 1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1'b0, st);
    check32("t1_stall", 32'(st), 32'd2);
    check32("t1_addr", dmem_addr, 32'h1000);
    check32("t1_wstrb", 32'(dmem_wstrb), 32'hF);
    check32("t1_wdata", dmem_wdata, 32'hDEADBEEF);

    // 2: SB at byte 3
    do_txn(1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 1'b0, 1'b0, st);
    check32("t2_wdata", dmem_wdata, 32'hA5A5A5A5);
    check32("t2_wstrb", 32'(dmem_wstrb), 32'h8);
    check32("t2_addr", dmem_addr, 32'h1000);

    // 3: LB then LBU with 3 wait cycles; request held through release
    do_txn(1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 32'h12F03456, 3, 1'b0, 1'b1, st);
    check32("t3_lb_stall", 32'(st), 32'd5);
    check32("t3_lb", load_data, 32'hFFFFFFF0);
    do_txn(1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 32'h12F03456, 3, 1'b0, 1'b1, st);
    check32("t3_lbu", load_data, 32'h000000F0);

    // 4: misaligned LH and LW fault without any access
    do_txn(1'b1, 1'b0, 3'b001, 32'h2001, 32'h0, 32'hFFFFFFFF, 0, 1'b0, 1'b0, st);
    do_txn(1'b1, 1'b0, 3'b010, 32'h2002, 32'h0, 32'hFFFFFFFF, 0, 1'b0, 1'b0, st);
    do_txn(1'b1, 1'b1, 3'b010, 32'h2000, 32'h0, 32'hFFFFFFFF, 0, 1'b0, 1'b0, st);
    check32("t4_load_held", load_data, 32'h000000F0);

    // 5: reset during ACCESS of a load
    mem_read = 1; funct3 = 3'b010; address = 32'h3000; dmem_busywait = 1;
    m_busy = 1;
    @(posedge clk); #1;
    m_read = 1; m_addr = 32'h3000; m_wstrb = 4'h0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; mem_read = 0; dmem_busywait = 0;
    m_read = 0; m_busy = 0; m_addr = 0; m_wstrb = 0; m_wdata = 0; m_load = 0;
    check32("t5_read_dropped", 32'(dmem_read), 32'd0);
    check32("t5_load_cleared", load_data, 32'd0);
    check32("t5_fsm_idle", 32'(dbg_state), 32'd0);
    do_txn(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'hCAFEF00D, 1, 1'b0, 1'b0, st);
    check32("t5_reissue", load_data, 32'hCAFEF00D);

`ifdef MEM_TIMEOUT_EN
    // 6: memory never answers; abort after TMO access cycles
    do_txn(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h55555555, 0, 1'b1, 1'b0, st);
    check32("t6_load_held", load_data, 32'hCAFEF00D);
`endif

    // randomized transactions
    for (int n = 0; n < 80; n++) begin
      bit rd, wr;
      int kind;
      kind = $urandom_range(0, 9);
      rd = (kind < 5) || (kind == 9);
      wr = (kind >= 5);
      do_txn(rd, wr, 3'($urandom_range(0, 7)),
             $urandom_range(0, 255) * 4 + $urandom_range(0, 3),
             $urandom, $urandom, $urandom_range(0, 3), 1'b0,
             1'($urandom_range(0, 1)), st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;   // idle gap
      end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
